// File: rtl/rst_seq_defs.sv
// Shared definitions for the reset sequencer: FSM state encodings.
package rst_seq_defs;

  localparam int unsigned ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_HOLD = 2'd0,
    ST_CAL  = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/cycle_counter.sv
// Up-counter with synchronous clear/enable and a terminal-count compare.
module cycle_counter #(
  parameter int unsigned CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;

  // Count register: cleared on reset or clr, otherwise advances when enabled.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/reset_sequencer.sv
// Staged bring-up for the ADC digital core: hold core reset, launch calibration,
// wait for completion (bounded by a timeout), then report ready or a sticky error.
module reset_sequencer
  import rst_seq_defs::*;
#(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned CAL_TIMEOUT = 1024,
  parameter int unsigned CNT_W       = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            soft_rst_req,
  input  logic            cal_done,
  output logic            core_rst,
  output logic            cal_start,
  output logic            ready,
  output logic            timeout_err,
  output logic [ST_W-1:0] state
);

  if (HOLD_CYCLES < 1 || CAL_TIMEOUT < 1 ||
      longint'(HOLD_CYCLES) > (longint'(1) << CNT_W) - 1 ||
      longint'(CAL_TIMEOUT) > (longint'(1) << CNT_W) - 1) begin : g_param_check
    $error("reset_sequencer: HOLD_CYCLES/CAL_TIMEOUT must be >= 1 and fit in CNT_W bits");
  end

  // HOLD leaves on the edge after HOLD_CYCLES counted edges; CAL times out once
  // the counter sits at CAL_TIMEOUT-1 without cal_done.
  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CAL_TERM  = CNT_W'(CAL_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             core_rst_q, core_rst_d;
  logic             cal_start_q, cal_start_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0] cnt_term;

  cycle_counter #(
    .CNT_W(CNT_W)
  ) u_cycle_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .term(cnt_term),
    .tc  (cnt_tc)
  );

  // State and output registers; rst forces the reset values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HOLD;
      core_rst_q  <= 1'b1;
      cal_start_q <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      core_rst_q  <= core_rst_d;
      cal_start_q <= cal_start_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
    end
  end

  // Next-state, next-output and counter control.
  always_comb begin
    state_d     = state_q;
    core_rst_d  = core_rst_q;
    cal_start_d = 1'b0;
    ready_d     = ready_q;
    err_d       = err_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    cnt_term    = HOLD_TERM;

    if (soft_rst_req) begin
      // Restart from HOLD; the error flag deliberately survives.
      state_d    = ST_HOLD;
      core_rst_d = 1'b1;
      ready_d    = 1'b0;
      cnt_clr    = 1'b1;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          cnt_term = HOLD_TERM;
          if (cnt_tc) begin
            state_d     = ST_CAL;
            core_rst_d  = 1'b0;
            cal_start_d = 1'b1;
            cnt_clr     = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_CAL: begin
          cnt_term = CAL_TERM;
          // cal_done outranks a timeout landing in the same cycle.
          if (cal_done) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
            cnt_clr = 1'b1;
          end else if (cnt_tc) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_RUN: begin
          core_rst_d = 1'b0;
          ready_d    = 1'b1;
        end
        ST_ERR: begin
          core_rst_d = 1'b0;
          ready_d    = 1'b0;
        end
        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end
  end

  assign core_rst    = core_rst_q;
  assign cal_start   = cal_start_q;
  assign ready       = ready_q;
  assign timeout_err = err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scenario bench for reset_sequencer (HOLD_CYCLES=4, CAL_TIMEOUT=8). Each scenario
// builds a per-cycle plan of inputs and expected registered outputs; expectations are
// queued as each cycle is driven and popped once the edge has produced the outputs.
module tb_reset_sequencer;
  import rst_seq_defs::*;

  localparam int unsigned HOLD = 4;
  localparam int unsigned TMO  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       soft_rst_req = 1'b0;
  logic       cal_done = 1'b0;
  logic       core_rst, cal_start, ready, timeout_err;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // {state[1:0], core_rst, cal_start, ready, timeout_err}
  typedef struct packed {
    logic       r;
    logic       s;
    logic       c;
    logic [5:0] e;
  } stim_t;

  stim_t      plan[$];
  logic [5:0] exp_q[$];

  reset_sequencer #(
    .HOLD_CYCLES(HOLD),
    .CAL_TIMEOUT(TMO),
    .CNT_W      (11)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .soft_rst_req(soft_rst_req),
    .cal_done    (cal_done),
    .core_rst    (core_rst),
    .cal_start   (cal_start),
    .ready       (ready),
    .timeout_err (timeout_err),
    .state       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] ex(logic [1:0] st, logic cr, logic cs, logic rd, logic te);
    return {st, cr, cs, rd, te};
  endfunction

  function automatic void add(logic r, logic s, logic c, logic [5:0] e);
    stim_t p;
    p.r = r; p.s = s; p.c = c; p.e = e;
    plan.push_back(p);
  endfunction

  function automatic void add_reset();
    add(1'b1, 1'b0, 1'b0, ex(ST_HOLD, 1'b1, 1'b0, 1'b0, 1'b0));
  endfunction

  // n counted HOLD edges; cal_done level cd must be ignored there.
  function automatic void add_hold(int n, logic te, logic cd);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, cd, ex(ST_HOLD, 1'b1, 1'b0, 1'b0, te));
  endfunction

  // Entry edge into CAL, then CAL cycles 1..TMO. cal_done is held high during CAL
  // cycle done_at (0 = never); the edge ending that cycle moves to RUN. With no
  // cal_done the edge ending CAL cycle TMO moves to ERR.
  function automatic void add_cal(int done_at, logic te);
    add(1'b0, 1'b0, 1'b0, ex(ST_CAL, 1'b0, 1'b1, 1'b0, te));
    for (int j = 1; j <= int'(TMO); j++) begin
      if (j == done_at) begin
        add(1'b0, 1'b0, 1'b1, ex(ST_RUN, 1'b0, 1'b0, 1'b1, te));
        return;
      end else if (j == int'(TMO)) begin
        add(1'b0, 1'b0, 1'b0, ex(ST_ERR, 1'b0, 1'b0, 1'b0, 1'b1));
      end else begin
        add(1'b0, 1'b0, 1'b0, ex(ST_CAL, 1'b0, 1'b0, 1'b0, te));
      end
    end
  endfunction

  function automatic void add_stay(int n, logic [1:0] st, logic cd, logic te);
    for (int i = 0; i < n; i++)
      add(1'b0, 1'b0, cd, ex(st, 1'b0, 1'b0, (st == ST_RUN), te));
  endfunction

  function automatic void add_soft(int n, logic te);
    for (int i = 0; i < n; i++) add(1'b0, 1'b1, 1'b0, ex(ST_HOLD, 1'b1, 1'b0, 1'b0, te));
  endfunction

  task automatic tick(input stim_t p);
    rst          = p.r;
    soft_rst_req = p.s;
    cal_done     = p.c;
    exp_q.push_back(p.e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] got, e;
    int n = 0;
    plan.delete();
    add_reset();
    add_reset();
    // rst outranks a simultaneous soft reset request
    add(1'b1, 1'b1, 1'b1, ex(ST_HOLD, 1'b1, 1'b0, 1'b0, 1'b0));
    while (plan.size() > 0) begin
      tick(plan.pop_front());
      got = {state, core_rst, cal_start, ready, timeout_err};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset cyc %0d: got %b expected %b (st,core_rst,cal_start,ready,err)",
                 n, got, e);
      end
      n++;
    end
  endtask

  task automatic test_bringup();
    logic [5:0] got, e;
    int n = 0;
    plan.delete();
    add_reset();
    add_hold(HOLD, 1'b0, 1'b0);
    add_cal(3, 1'b0);
    add_stay(3, ST_RUN, 1'b0, 1'b0);
    while (plan.size() > 0) begin
      tick(plan.pop_front());
      got = {state, core_rst, cal_start, ready, timeout_err};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL bringup cyc %0d: got %b expected %b (st,core_rst,cal_start,ready,err)",
                 n, got, e);
      end
      n++;
    end
  endtask

  task automatic test_timeout();
    logic [5:0] got, e;
    int n = 0;
    plan.delete();
    add_reset();
    add_hold(HOLD, 1'b0, 1'b0);
    add_cal(0, 1'b0);
    add_stay(2, ST_ERR, 1'b1, 1'b1);
    add_reset();
    while (plan.size() > 0) begin
      tick(plan.pop_front());
      got = {state, core_rst, cal_start, ready, timeout_err};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL timeout cyc %0d: got %b expected %b (st,core_rst,cal_start,ready,err)",
                 n, got, e);
      end
      n++;
    end
  endtask

  task automatic test_tie();
    logic [5:0] got, e;
    int n = 0;
    plan.delete();
    add_reset();
    add_hold(HOLD, 1'b0, 1'b0);
    add_cal(TMO, 1'b0);
    add_stay(2, ST_RUN, 1'b0, 1'b0);
    while (plan.size() > 0) begin
      tick(plan.pop_front());
      got = {state, core_rst, cal_start, ready, timeout_err};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL tie cyc %0d: got %b expected %b (st,core_rst,cal_start,ready,err)",
                 n, got, e);
      end
      n++;
    end
  endtask

  task automatic test_soft_reset();
    logic [5:0] got, e;
    int n = 0;
    plan.delete();
    // From RUN
    add_reset();
    add_hold(HOLD, 1'b0, 1'b0);
    add_cal(2, 1'b0);
    add_stay(1, ST_RUN, 1'b0, 1'b0);
    add_soft(3, 1'b0);
    add_hold(HOLD, 1'b0, 1'b0);
    add_cal(2, 1'b0);
    // From ERR: the error flag survives the rerun
    add_reset();
    add_hold(HOLD, 1'b0, 1'b0);
    add_cal(0, 1'b0);
    add_stay(1, ST_ERR, 1'b0, 1'b1);
    add_soft(3, 1'b1);
    add_hold(HOLD, 1'b1, 1'b0);
    add_cal(0, 1'b1);
    add_soft(1, 1'b1);
    add_hold(HOLD, 1'b1, 1'b0);
    add_cal(5, 1'b1);
    while (plan.size() > 0) begin
      tick(plan.pop_front());
      got = {state, core_rst, cal_start, ready, timeout_err};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL soft_reset cyc %0d: got %b expected %b (st,core_rst,cal_start,ready,err)",
                 n, got, e);
      end
      n++;
    end
  endtask

  task automatic test_mid_rst();
    logic [5:0] got, e;
    int n = 0;
    plan.delete();
    add_reset();
    add_hold(HOLD, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, ex(ST_CAL, 1'b0, 1'b1, 1'b0, 1'b0));
    add(1'b0, 1'b0, 1'b0, ex(ST_CAL, 1'b0, 1'b0, 1'b0, 1'b0));
    add_reset();
    add_hold(HOLD, 1'b0, 1'b0);
    add_cal(2, 1'b0);
    while (plan.size() > 0) begin
      tick(plan.pop_front());
      got = {state, core_rst, cal_start, ready, timeout_err};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mid_rst cyc %0d: got %b expected %b (st,core_rst,cal_start,ready,err)",
                 n, got, e);
      end
      n++;
    end
  endtask

  task automatic test_spurious();
    logic [5:0] got, e;
    int n = 0;
    plan.delete();
    add_reset();
    add_hold(HOLD, 1'b0, 1'b1);
    add_cal(4, 1'b0);
    add_stay(2, ST_RUN, 1'b1, 1'b0);
    add_stay(1, ST_RUN, 1'b0, 1'b0);
    add_stay(1, ST_RUN, 1'b1, 1'b0);
    while (plan.size() > 0) begin
      tick(plan.pop_front());
      got = {state, core_rst, cal_start, ready, timeout_err};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL spurious cyc %0d: got %b expected %b (st,core_rst,cal_start,ready,err)",
                 n, got, e);
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_timeout();
    test_tie();
    test_soft_reset();
    test_mid_rst();
    test_spurious();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
